// File: rtl/alu_pkg.sv
// Shared types for the pin-driven ALU sequencer: op/command encodings, FSM states, flags.
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000, OP_SRL = 3'b001, OP_AND = 3'b010, OP_SRA  = 3'b011,
    OP_SUB  = 3'b100, OP_SLL = 3'b101, OP_OR  = 3'b110, OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_LOAD_A, CMD_LOAD_B, CMD_EXEC,
    CMD_EXEC_ACC, CMD_SHOW_FLAGS, CMD_SHOW_RESULT, CMD_CLEAR
  } cmd_e;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  localparam logic [7:0] UIO_OE = 8'hF0;
endpackage

// File: rtl/alu_8bits_core.sv
// Combinational 8-bit ALU: add/sub through the CLA, logic ops, single-bit shifts of S.
module alu_8bits_core
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_e    op,
  input  logic       sh_sel,
  output logic [7:0] y,
  output logic       c,
  output logic       z,
  output logic       n,
  output logic       v
);
  logic       is_sub, cout;
  logic [7:0] b_eff, sum, s;

  // Subtract is A + ~B + 1, so carry-out high means no borrow.
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign s      = sh_sel ? a : b;

  cla_8bits u_cla (.a(a), .b(b_eff), .cin(is_sub), .sum(sum), .cout(cout));

  always_comb begin
    y = sum;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD:  begin y = sum; c = cout; v = (a[7] == b[7]) & (sum[7] != a[7]); end
      OP_SUB:  begin y = sum; c = cout; v = (a[7] != b[7]) & (sum[7] != a[7]); end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SRL:  begin y = {1'b0, s[7:1]}; c = s[0]; end
      OP_SLL:  begin y = {s[6:0], 1'b0}; c = s[7]; end
      OP_SRA:  begin y = {s[7], s[7:1]}; c = s[0]; end
      OP_PASS: y = s;
      default: y = sum;
    endcase
  end

  assign z = (y == 8'h00);
  assign n = y[7];
endmodule

// File: rtl/cla_8bits.sv
// 8-bit carry-lookahead adder: generate/propagate per bit, carries from the lookahead recurrence.
module cla_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g, p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];
endmodule

// File: rtl/tt_um_alu_sequencer.sv
// TinyTapeout top: strobe/command handshake sequencing the ALU core, with result/flag display.
module tt_um_alu_sequencer
  import alu_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  state_e     state;
  logic       s1, s2, s3, stb_rise, accept;
  logic [7:0] a_q, b_q, r_q;
  alu_op_e    op_q;
  logic       sh_q, ovr_q, valid_q, disp_flags;
  flags_t     fl_q;
  cmd_e       cmd;
  logic [7:0] y;
  logic       y_c, y_z, y_n, y_v;
  logic       unused_pins;

  assign unused_pins = &{1'b0, uio_in[7:4]};
  assign cmd      = cmd_e'(uio_in[3:1]);
  assign stb_rise = s2 & ~s3;
  assign accept   = stb_rise & ena & (state == IDLE);

  alu_8bits_core u_core (
    .a(a_q), .b(b_q), .op(op_q), .sh_sel(sh_q),
    .y(y), .c(y_c), .z(y_z), .n(y_n), .v(y_v)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      {s1, s2, s3} <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      op_q       <= OP_ADD;
      sh_q       <= 1'b0;
      fl_q       <= '0;
      ovr_q      <= 1'b0;
      valid_q    <= 1'b0;
      disp_flags <= 1'b0;
    end else begin
      s1 <= uio_in[0];
      s2 <= s1;
      s3 <= s2;
      // A strobe edge while busy is dropped but remembered.
      if (stb_rise && ena && state != IDLE) ovr_q <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          case (cmd)
            CMD_LOAD_A: begin a_q <= ui_in; valid_q <= 1'b0; end
            CMD_LOAD_B: begin b_q <= ui_in; valid_q <= 1'b0; end
            CMD_EXEC, CMD_EXEC_ACC: begin
              op_q    <= alu_op_e'(ui_in[2:0]);
              sh_q    <= ui_in[3];
              valid_q <= 1'b0;
              if (cmd == CMD_EXEC_ACC) a_q <= r_q;
              state   <= EXEC;
            end
            CMD_SHOW_FLAGS:  disp_flags <= 1'b1;
            CMD_SHOW_RESULT: disp_flags <= 1'b0;
            CMD_CLEAR: begin
              a_q        <= '0;
              b_q        <= '0;
              r_q        <= '0;
              fl_q       <= '0;
              ovr_q      <= 1'b0;
              valid_q    <= 1'b0;
              disp_flags <= 1'b0;
            end
            default: ;
          endcase
        end
        EXEC: begin
          r_q        <= y;
          fl_q       <= '{c: y_c, z: y_z, n: y_n, v: y_v};
          disp_flags <= 1'b0;
          valid_q    <= 1'b1;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out  = disp_flags ? {3'b000, ovr_q, fl_q} : r_q;
  assign uio_out = {fl_q.v, fl_q.c, valid_q, state != IDLE, 4'b0000};
  assign uio_oe  = UIO_OE;
endmodule

// File: tb/tb_tt_um_alu_sequencer.sv
// Scoreboarded bench for tt_um_alu_sequencer: EXEC results are queued at issue and checked in DONE.
module tb_tt_um_alu_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;

  tt_um_alu_sequencer dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] ma = 0, mb = 0, mr = 0;
  logic       mc = 0, mz = 0, mn = 0, mv = 0, movr = 0;

  function automatic logic [7:0] flag_word();
    return {3'b000, movr, mc, mz, mn, mv};
  endfunction

  function automatic void model_exec(input logic [2:0] op, input logic sh);
    logic [7:0] s;
    logic [8:0] w;
    int         si;
    s  = sh ? ma : mb;
    mc = 1'b0;
    mv = 1'b0;
    case (op)
      3'b000: begin
        w = {1'b0, ma} + {1'b0, mb}; mr = w[7:0]; mc = w[8];
        si = int'($signed(ma)) + int'($signed(mb)); mv = (si > 127) || (si < -128);
      end
      3'b100: begin
        w = {1'b0, ma} + {1'b0, ~mb} + 9'd1; mr = w[7:0]; mc = w[8];
        si = int'($signed(ma)) - int'($signed(mb)); mv = (si > 127) || (si < -128);
      end
      3'b010: mr = ma & mb;
      3'b110: mr = ma | mb;
      3'b001: begin mr = s >> 1; mc = s[0]; end
      3'b101: begin mr = s << 1; mc = s[7]; end
      3'b011: begin mr = $signed(s) >>> 1; mc = s[0]; end
      default: mr = s;
    endcase
    mz = (mr == 8'h00);
    mn = mr[7];
  endfunction

  function automatic void model_clear();
    ma = 0; mb = 0; mr = 0; mc = 0; mz = 0; mn = 0; mv = 0; movr = 0;
  endfunction

  // Completion monitor: DONE is the only state with busy and valid both high.
  always @(negedge clk) begin
    if (rst_n && uio_out[4] && uio_out[5]) begin
      exp_t e;
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL done_unexpected: uo_out=%02h with no pending result", uo_out);
      end else begin
        e = sbq.pop_front();
        if (uo_out !== e.r || uio_out[7:6] !== {e.v, e.c}) begin
          miscompares++;
          $display("FAIL exec_result: got R=%02h VC=%b, want R=%02h VC=%b",
                   uo_out, uio_out[7:6], e.r, {e.v, e.c});
        end
      end
    end
  end

  // One handshake: strobe high across the accept and the full EXEC/DONE window, then low.
  task automatic send(input logic [2:0] cmd, input logic [7:0] d);
    bit is_exec;
    is_exec = ena && (cmd == 3'd3 || cmd == 3'd4);
    @(negedge clk);
    ui_in  = d;
    uio_in = {4'b0000, cmd, 1'b1};
    if (ena) begin
      case (cmd)
        3'd1: ma = d;
        3'd2: mb = d;
        3'd3: model_exec(d[2:0], d[3]);
        3'd4: begin ma = mr; model_exec(d[2:0], d[3]); end
        3'd7: model_clear();
        default: ;
      endcase
      if (is_exec) sbq.push_back('{r: mr, c: mc, v: mv});
    end
    repeat (3) @(negedge clk);
    if (is_exec) begin
      vectors++;
      if (uio_out[4] !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_exec: got %b want 1", uio_out[4]);
      end
    end
    @(negedge clk);
    uio_in[0] = 1'b0;
    if (is_exec) begin
      vectors++;
      if (uio_out[4] !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_done: got %b want 1", uio_out[4]);
      end
    end
    @(negedge clk);
    if (is_exec) begin
      vectors++;
      if (uio_out[4] !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_idle: got %b want 0", uio_out[4]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (uio_oe !== 8'hF0) begin
      miscompares++;
      $display("FAIL reset_oe: got %02h want f0", uio_oe);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out: got uo=%02h uio=%02h want 00 00", uo_out, uio_out);
    end
  endtask

  task automatic test_add_overflow();
    send(3'd1, 8'h7F);
    send(3'd2, 8'h01);
    send(3'd3, 8'h00);
    send(3'd5, 8'h00);
    vectors++;
    if (uo_out !== 8'h03 || uio_out[7:5] !== 3'b101) begin
      miscompares++;
      $display("FAIL add_flags: got uo=%02h uio[7:5]=%b want 03 101", uo_out, uio_out[7:5]);
    end
  endtask

  task automatic test_sub_zero();
    send(3'd1, 8'h05);
    send(3'd2, 8'h05);
    send(3'd3, 8'h04);
    send(3'd5, 8'h00);
    vectors++;
    if (uo_out !== 8'h0C) begin
      miscompares++;
      $display("FAIL sub_flags: got %02h want 0c", uo_out);
    end
  endtask

  task automatic test_acc_chain();
    send(3'd1, 8'h7F);
    send(3'd2, 8'h01);
    send(3'd3, 8'h00);
    send(3'd4, 8'h0B);
    send(3'd5, 8'h00);
    vectors++;
    if (uo_out !== 8'h02) begin
      miscompares++;
      $display("FAIL acc_flags: got %02h want 02", uo_out);
    end
  endtask

  task automatic test_all_ops();
    logic [7:0] av, bv;
    for (int k = 0; k < 4; k++) begin
      for (int op = 0; op < 8; op++) begin
        case (k)
          0: begin av = 8'h80; bv = 8'h80; end
          1: begin av = 8'hFF; bv = 8'h01; end
          default: begin av = 8'($urandom); bv = 8'($urandom); end
        endcase
        send(3'd1, av);
        send(3'd2, bv);
        send(3'd3, {4'b0000, (k[0] ^ op[1]), 3'(op)});
      end
    end
    send(3'd5, 8'h00);
    vectors++;
    if (uo_out !== flag_word()) begin
      miscompares++;
      $display("FAIL ops_flags: got %02h want %02h", uo_out, flag_word());
    end
  endtask

  // Second strobe edge lands in DONE; it must be dropped and latch ovr.
  task automatic test_overrun();
    send(3'd1, 8'h11);
    send(3'd2, 8'h22);
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = {4'b0000, 3'd3, 1'b1};
    model_exec(3'b000, 1'b0);
    sbq.push_back('{r: mr, c: mc, v: mv});
    @(negedge clk); uio_in[0] = 1'b0;
    @(negedge clk); uio_in[0] = 1'b1;
    @(negedge clk); ui_in = 8'h5A; uio_in = {4'b0000, 3'd1, 1'b1};
    repeat (2) @(negedge clk);
    uio_in = 8'h00;
    movr = 1'b1;
    repeat (3) @(negedge clk);
    send(3'd5, 8'h00);
    vectors++;
    if (uo_out !== flag_word() || uo_out[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_flags: got %02h want %02h", uo_out, flag_word());
    end
    send(3'd6, 8'h00);
    vectors++;
    if (uo_out !== 8'h33) begin
      miscompares++;
      $display("FAIL ovr_result: got %02h want 33", uo_out);
    end
    send(3'd3, 8'h0F);
    send(3'd7, 8'h00);
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_out: got uo=%02h uio=%02h want 00 00", uo_out, uio_out);
    end
    send(3'd5, 8'h00);
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_flags: got %02h want 00", uo_out);
    end
  endtask

  task automatic test_reset_mid_exec();
    send(3'd1, 8'h10);
    send(3'd2, 8'h20);
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = {4'b0000, 3'd3, 1'b1};
    repeat (3) @(negedge clk);
    vectors++;
    if (uio_out[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_busy: got %b want 1", uio_out[4]);
    end
    rst_n  = 1'b0;
    uio_in = 8'h00;
    @(negedge clk);
    vectors++;
    if (uio_out !== 8'h00 || uo_out !== 8'h00 || uio_oe !== 8'hF0) begin
      miscompares++;
      $display("FAIL rst_mid_exec: got uo=%02h uio=%02h oe=%02h want 00 00 f0",
               uo_out, uio_out, uio_oe);
    end
    rst_n = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_no_writeback: got uo=%02h uio=%02h want 00 00", uo_out, uio_out);
    end
  endtask

  task automatic test_ena_low();
    send(3'd7, 8'h00);
    ena = 1'b0;
    send(3'd1, 8'h55);
    ena = 1'b1;
    send(3'd3, 8'h0F);
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL ena_pass: got %02h want 00", uo_out);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_acc_chain();
    test_all_ops();
    test_overrun();
    test_reset_mid_exec();
    test_ena_low();
    repeat (4) @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending results want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tt_um_alu_sequencer.md
# tt_um_alu_sequencer

TinyTapeout top-level controller that sequences the 8-bit ALU datapath from the pins. The 8-bit pin bus loads operands A and B serially and issues ALU commands through a strobe/command handshake. The block registers the result and flags, supports accumulator chaining (result fed back as A), and exposes busy/valid status on the bidirectional pins.

## Interface
- No parameters; widths fixed at 8 bits.
- clk  in  1  single system clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  TinyTapeout enable; low blocks command acceptance.
- ui_in  in  8  data bus: operand value, or {4'bx, sh_sel, op[2:0]} for EXEC commands.
- uio_in  in  8  [0] strobe, [3:1] cmd; [7:4] unused.
- uo_out  out  8  display register: result R or flag word.
- uio_out  out  8  [4] busy, [5] valid, [6] C, [7] V; [3:0] = 0.
- uio_oe  out  8  constant 8'hF0, including during reset.

## Operation
- Strobe path: 2-flop synchronizer (s1, s2) plus edge flop s3. A command is accepted when s2 & ~s3 & ena & state==IDLE. cmd and ui_in are sampled in the accept cycle, so the host holds them stable ≥3 cycles after raising strobe.
- Commands (cmd):
  - 000 NOP.
  - 001 LOAD_A: A←ui_in.
  - 010 LOAD_B: B←ui_in.
  - 011 EXEC: op←ui_in[2:0], sh_sel←ui_in[3].
  - 100 EXEC_ACC: same as EXEC, and A←R.
  - 101 SHOW_FLAGS.
  - 110 SHOW_RESULT.
  - 111 CLEAR: A, B, R, flags, ovr, valid←0; display←result.
- ALU op encoding:
  - 000 add A+B, carry-in 0.
  - 100 sub A+~B+1; C=1 means no borrow.
  - 010 AND; 110 OR.
  - 001 SRL of S; 101 SLL of S; 011 SRA of S.
  - 111 pass S.
  - S = sh_sel ? A : B.
- Flag rules:
  - Shifts: C = bit shifted out.
  - Logic and pass ops: C=0, V=0.
  - Add: V = (A[7]==B[7]) & (Y[7]!=A[7]).
  - Sub: V = (A[7]!=B[7]) & (Y[7]!=A[7]).
  - All ops: Z = (Y==0), N = Y[7].
- FSM states: IDLE → EXEC (one cycle) → DONE (one cycle) → IDLE.
  - Only EXEC and EXEC_ACC leave IDLE; all other commands complete in the accept cycle.
- Flag word: {3'b000, ovr, C, Z, N, V}.
- uo_out: registered; shows R when display=result, flag word when display=flags. Completion of an EXEC sets display←result.
- valid: set on entry to DONE. Cleared by any accepted LOAD_A, LOAD_B, EXEC, EXEC_ACC or CLEAR.
- ovr: sticky. Set when a strobe rising edge (s2 & ~s3) occurs while state≠IDLE. The command is dropped. Only CLEAR or reset clears ovr.
- ena low: no commands accepted and no ovr set. An in-flight EXEC still completes.

## Timing
- Accept cycle t: operand/op registers updated at the end of t.
- EXEC in t+1: core evaluates and writes R, C, Z, N, V at the end of t+1.
- DONE in t+2: busy=1, valid=1; uo_out shows the new R (display=result).
- Back in IDLE at t+3, where a new command can be accepted.
- busy=1 exactly during EXEC and DONE.
- Pin-to-accept latency: strobe must be high at 2 clock edges before acceptance (synchronizer latency).
- Reset (rst_n sampled low at any edge, including mid-EXEC or DONE):
  - State IDLE; A, B, R, flags, ovr, valid, s1–s3 = 0; display = result.
  - Outputs next cycle: uo_out=0, uio_out=0, uio_oe=8'hF0.
  - No write-back from an aborted EXEC.
- A strobe held high yields exactly one accept; strobe must return low before the next command.

## Structure
- Package alu_pkg:
  - alu_op_e (8 op codes) and cmd_e (8 commands).
  - state_e {IDLE, EXEC, DONE}.
  - packed flags_t {C, Z, N, V}.
  - Constant UIO_OE = 8'hF0.
- Sub-module alu_8bits_core: purely combinational. Inputs A, B, op, sh_sel; outputs Y, C, Z, N, V. Add and subtract use the existing cla_8bits. The sequencer instantiates it once.

## Test plan
- LOAD_A 0x7F, LOAD_B 0x01, EXEC ui_in=0x00 → busy for 2 cycles; R=0x80 at t+2, valid=1. Then SHOW_FLAGS → uo_out=0x03, uio_out[7:6]=2'b10.
- LOAD_A 0x05, LOAD_B 0x05, EXEC op=100 → R=0x00; SHOW_FLAGS → 0x0C (C=1, Z=1).
- After R=0x80: EXEC_ACC ui_in=0x0B (SRA, sh_sel=1) → A=0x80, R=0xC0; flags 0x02.
- Strobe pulse while busy → command dropped, R unchanged, flags bit4=1. CLEAR → uo_out=0, flag word 0x00.
- rst_n low during the EXEC cycle → next cycle busy=0, valid=0, uo_out=0x00, uio_oe=0xF0, no result written.
- ena=0, LOAD_A 0x55 with strobe → A unchanged. Subsequent EXEC pass (ui_in=0x0F) → R=0x00.
